// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Registered WIDTH-bit logic lane: applies one of eight bitwise functions to
//   operands A and B, holds the result in a single-entry output register
//   guarded by a valid/ready handshake, and keeps an accumulator that can
//   stand in for operand A so that operations can be chained.
//
//   Opcodes: 0 ~X, 1 ~B, 2 X|B, 3 ~(X|B), 4 X&B, 5 ~(X&B), 6 X^B, 7 ~(X^B)
//   where X = in_acc ? acc : in_a.
//
// Parameters
//   WIDTH     operand/result width in bits (>=1)
//   ACC_INIT  accumulator value after reset and after in_clr
//
// Ports
//   clk        clock, rising-edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand/opcode presented
//   in_ready   block can accept this cycle (!out_valid || out_ready)
//   in_a/in_b  operands
//   in_sel     function select
//   in_acc     use accumulator in place of in_a
//   in_clr     synchronous accumulator clear (wins over a result write)
//   out_valid  result register holds an unconsumed result
//   out_ready  downstream accepts result
//   out_s      result
//   out_sel    opcode that produced out_s
//
// Optional build macro LU_FLAGS_EN adds registered result flags:
//   out_zero (out_s == 0), out_parity (^out_s), out_ones (out_s all ones)
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
   parameter int unsigned           WIDTH    = 8,
   parameter logic [WIDTH-1:0]      ACC_INIT = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_sel,
   input  logic             in_acc,
   input  logic             in_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_s,
`ifdef LU_FLAGS_EN
   output logic             out_zero,
   output logic             out_parity,
   output logic             out_ones,
`endif
   output logic [2:0]       out_sel
);

   typedef enum logic [2:0] {
      OP_NOTA = 3'd0,
      OP_NOTB = 3'd1,
      OP_OR   = 3'd2,
      OP_NOR  = 3'd3,
      OP_AND  = 3'd4,
      OP_NAND = 3'd5,
      OP_XOR  = 3'd6,
      OP_XNOR = 3'd7
   } op_e;

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [2:0]       sel_q, sel_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] f;
   logic             accept;
   logic             pop;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign pop      = valid_q && out_ready;
   assign x        = in_acc ? acc_q : in_a;

   always_comb begin
      f = '0;
      case (op_e'(in_sel))
         OP_NOTA: f = ~x;
         OP_NOTB: f = ~in_b;
         OP_OR:   f = x | in_b;
         OP_NOR:  f = ~(x | in_b);
         OP_AND:  f = x & in_b;
         OP_NAND: f = ~(x & in_b);
         OP_XOR:  f = x ^ in_b;
         OP_XNOR: f = ~(x ^ in_b);
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      s_d     = s_q;
      sel_d   = sel_q;
      acc_d   = acc_q;
      if (accept) begin
         valid_d = 1'b1;
         s_d     = f;
         sel_d   = in_sel;
         acc_d   = f;
      end else if (pop) begin
         valid_d = 1'b0;
      end
      // Clear is applied after the result write so it takes priority; the
      // operation itself has already used the pre-clear accumulator via x.
      if (in_clr) begin
         acc_d = ACC_INIT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         s_q     <= '0;
         sel_q   <= '0;
         acc_q   <= ACC_INIT;
      end else begin
         valid_q <= valid_d;
         s_q     <= s_d;
         sel_q   <= sel_d;
         acc_q   <= acc_d;
      end
   end

   assign out_valid = valid_q;
   assign out_s     = s_q;
   assign out_sel   = sel_q;

`ifdef LU_FLAGS_EN
   logic zero_q, parity_q, ones_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q   <= 1'b1;
         parity_q <= 1'b0;
         ones_q   <= 1'b0;
      end else if (accept) begin
         zero_q   <= (f == '0);
         parity_q <= ^f;
         ones_q   <= (f == '1);
      end
   end

   assign out_zero   = zero_q;
   assign out_parity = parity_q;
   assign out_ones   = ones_q;
`endif

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the 8-function 1-bit logic selector.
- Applies one of eight bitwise functions to WIDTH-bit operands A and B. Opcode order: ~A, ~B, OR, NOR, AND, NAND, XOR, XNOR.
- Single result register with a valid/ready handshake.
- Accumulate mode chains operations by replacing A with the last result.
- Used as the logic lane of the datapath, downstream of operand fetch.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- ACC_INIT, 0, value loaded into the accumulator on reset and on in_clr.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_sel  input  3  function select (encoding below).
- in_acc  input  1  1 = use accumulator in place of in_a.
- in_clr  input  1  synchronous accumulator clear (load ACC_INIT).
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  downstream accepts result.
- out_s  output  WIDTH  result.
- out_sel  output  3  opcode that produced out_s.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_s=0, out_sel=0, acc=ACC_INIT, in_ready=1 once reset is released.
- Function encoding, bitwise over WIDTH, with X = in_acc ? acc : in_a:
  - 0: ~X
  - 1: ~in_b
  - 2: X|in_b
  - 3: ~(X|in_b)
  - 4: X&in_b
  - 5: ~(X&in_b)
  - 6: X^in_b
  - 7: ~(X^in_b)
- in_ready = !out_valid || out_ready (combinational, single-entry pipe).
- Accept when in_valid && in_ready: out_s <= f(X,in_b), out_sel <= in_sel, out_valid <= 1, acc <= f(X,in_b). Latency 1 cycle from accept to out_valid.
- Pop when out_valid && out_ready.
  - Pop without accept: out_valid <= 0; out_s and out_sel hold their last values.
  - Simultaneous pop and accept: the new result replaces the old one and out_valid stays 1. Full throughput is 1 op/cycle.
- Stall (out_valid && !out_ready):
  - in_ready=0.
  - out_s, out_sel and acc hold.
  - in_a, in_b, in_sel and in_acc are ignored.
- in_clr:
  - Effective every cycle regardless of handshake.
  - If no accept that cycle: acc <= ACC_INIT.
  - If accept in same cycle: the operation uses the pre-clear acc value, then acc <= ACC_INIT (clear wins over the result write).
- in_acc with in_sel=1: acc unused for the function; acc still updates with the result.
- Reset mid-stall: the pending result is discarded, out_valid drops immediately (asynchronous), and the accumulator reinitialises.
- No X propagation: out_s is always a registered value, never combinational from inputs.

Optional Feature:
- Macro: LU_FLAGS_EN.
- Defined, adds outputs:
  - out_zero (1): out_s == 0.
  - out_parity (1): ^out_s.
  - out_ones (1): out_s all ones.
- Flag behaviour: registered with out_s in the same accept cycle; reset to out_zero=1, out_parity=0, out_ones=0; hold during stall.
- Not defined: the three ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, then WIDTH=8, in_a=8'hF0, in_b=8'h3C, sweep in_sel 0..7 with out_ready=1 -> out_s = 0F, C3, FC, 03, 30, CF, CC, 33 on successive cycles; out_valid=1 every cycle after the first accept.
- Backpressure: accept sel=6 (a=AA, b=FF), hold out_ready=0 for 3 cycles while driving new operands -> in_ready=0, out_s stays 8'h55. Raise out_ready -> a simultaneous pop and accept occurs in that cycle.
- Accumulate chain: clr, then in_acc=1 with b=0F sel=2, b=F0 sel=6, b=FF sel=4 -> out_s = 0F, FF, FF, and acc=FF.
- Clear collision: acc=FF, assert in_clr with an accepted sel=4, in_acc=1, b=0F -> out_s=0F, and acc=ACC_INIT next cycle.
- Async reset asserted mid-stall, between clock edges -> out_valid=0 and out_s=0 immediately; the first op after release uses acc=ACC_INIT.
- LU_FLAGS_EN build: a=5A, b=5A, sel=6 -> out_zero=1, out_parity=0; sel=7 -> out_ones=1, out_zero=0.
